mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one unified backing-memory port between the instruction-fetch port (imem) and the data port (dmem) of the 5-stage pipeline.
- The EX stage issues dmem requests as single-cycle mask pulses. Fetch does the same on imem.
- This block latches each request and serialises the two onto the memory port, dmem first, with a starvation guard for imem.
- It routes each response back to the port that made the request.

Parameters:
- STARVE_MAX, 4, number of consecutive dmem grants made while imem is pending before imem is forced to win the next grant (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- imem_addr  in  32  fetch address, word-aligned
- imem_rmask  in  4  nonzero for one cycle = fetch request
- imem_rdata  out  32  fetch data, valid with imem_resp
- imem_resp  out  1  one-cycle fetch completion pulse
- dmem_addr  in  32  data address, bits [1:0] = 0
- dmem_rmask  in  4  load byte mask, nonzero = load request
- dmem_wmask  in  4  store byte mask, nonzero = store request
- dmem_wdata  in  32  store data, already lane-shifted
- dmem_rdata  out  32  load data, valid with dmem_resp
- dmem_resp  out  1  one-cycle data completion pulse
- mem_addr  out  32  backing-memory address
- mem_rmask  out  4  backing-memory read mask, one-cycle pulse
- mem_wmask  out  4  backing-memory write mask, one-cycle pulse
- mem_wdata  out  32  backing-memory write data
- mem_rdata  in  32  backing-memory read data
- mem_resp  in  1  backing-memory completion pulse, at least 1 cycle after issue
- dmem_err  out  1  sticky: a dmem request arrived while one was still pending

Behaviour:
- Request capture:
  - A port requests when its mask is nonzero in a cycle. For dmem, that means rmask or wmask is nonzero.
  - On that edge the addr, masks and wdata go into that port's pending slot and the slot's valid bit sets.
  - Each port has one slot. Upstream must not issue again on a port until its resp pulse.
  - A dmem request arriving while its slot is valid is dropped and sets dmem_err. A duplicate imem request is also dropped, with no error flag.
  - rmask and wmask both nonzero on dmem: treat as a store, rmask ignored.
- FSM states: IDLE, WAIT_I, WAIT_D. State and pending slots are flops.
- IDLE:
  - If any slot is valid, pick a grant, drive mem_* from the granted slot's registers in this cycle, and move to WAIT_I or WAIT_D on the edge.
  - Otherwise mem_rmask and mem_wmask are 0.
- Grant rule:
  - dmem wins when both slots are valid, unless starve_cnt == STARVE_MAX; then imem wins.
  - Requests arriving in the current cycle are not eligible until the next cycle.
- starve_cnt:
  - Increments on each dmem grant made while the imem slot is valid, saturating at STARVE_MAX.
  - Clears on any imem grant.
- WAIT_x:
  - mem_rmask and mem_wmask are 0; mem_addr and mem_wdata hold.
  - When mem_resp = 1: x_resp = 1 and x_rdata = mem_rdata in that same cycle (combinational pass-through). The x slot clears and the state returns to IDLE.
  - A store also produces dmem_resp, with dmem_rdata = mem_rdata (don't-care content).
- Simultaneous events:
  - A new request on port y in the same cycle as x completes is captured normally.
  - A new request on port x in the cycle of x_resp is legal. Capture wins over clear, so the slot stays valid with the new contents and dmem_err does not set.
- Latency:
  - Request at cycle 0, slot valid at 1, issue at 1, earliest resp at 2, next issue at 3.
  - No issue happens in a WAIT state.
- A mem_resp seen in IDLE is ignored.
- Reset at any time, including mid-transaction:
  - state = IDLE, both slots invalid, starve_cnt = 0, dmem_err = 0.
  - All resp and mask outputs = 0; rdata outputs = 0 while their resp is 0.
  - An outstanding backing-memory transaction is abandoned. Backing memory is reset by the same rst.

Decomposition:
- Shared package rv32i_types gets:
  - arb_state_t enum {IDLE, WAIT_I, WAIT_D}
  - mem_req_t struct {valid, addr, rmask, wmask, wdata}
- One sub-module, arb_req_slot: a single-entry capture register with the capture-over-clear rule and the duplicate flag. It is instantiated twice.

Test Plan:
- imem-only path: imem_rmask = 4'hF, addr 0x1000 at cycle 0 -> mem_rmask = F, mem_addr = 0x1000 at cycle 1; mem_resp at 3 with rdata 0xDEADBEEF -> imem_resp = 1, imem_rdata = 0xDEADBEEF at 3, and mem_rmask stays 0 during 2–3.
- Simultaneous requests: imem 0x1000 and dmem load 0x2004 (rmask 4'b0011) in the same cycle -> dmem issued first; imem issued in the cycle after dmem_resp + 1.
- Starvation guard: STARVE_MAX = 2, imem pending, dmem re-requests in every dmem_resp cycle -> grant order D, D, I, and starve_cnt returns to 0.
- Store path: dmem_wmask = 4'b1100, wdata 0xABCD0000, addr 0x3000 -> mem_wmask = C and mem_wdata = 0xABCD0000 for exactly one cycle; dmem_resp on mem_resp.
- Duplicate request: second dmem request while the first is pending -> dmem_err = 1 and stays set, original slot contents unchanged. A new request in the dmem_resp cycle -> accepted, dmem_err unaffected.
- Reset mid-operation: rst asserted while in WAIT_D with imem pending -> next cycle state = IDLE, no resp pulses, no issue; a late mem_resp is ignored.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared pipeline types used by the memory-port arbiter.
//   arb_state_t : arbiter FSM state (idle, waiting on fetch, waiting on data)
//   mem_req_t   : one captured memory request (valid + address/masks/data)
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port, data port, backing-memory
// port and the sticky dmem error flag.
//   master : the pipeline / backing-memory side (drives requests, mem_rdata, mem_resp)
//   slave  : the arbiter side (drives responses and the mem_* request lines)
interface mem_port_arbiter_if;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;

    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        dmem_err;

    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    modport master (
        output imem_addr, imem_rmask, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
               mem_rdata, mem_resp,
        input  imem_rdata, imem_resp, dmem_rdata, dmem_resp, dmem_err,
               mem_addr, mem_rmask, mem_wmask, mem_wdata
    );

    modport slave (
        input  imem_addr, imem_rmask, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
               mem_rdata, mem_resp,
        output imem_rdata, imem_resp, dmem_rdata, dmem_resp, dmem_err,
               mem_addr, mem_rmask, mem_wmask, mem_wdata
    );
endinterface

// File: rtl/arb_req_slot.sv
// Single-entry request capture register.
//   clk, rst  : clock, asynchronous active-high reset
//   req       : a new request is presented this cycle
//   req_data  : request contents to capture (valid field expected set)
//   clr       : the held request completes this cycle
//   slot      : held request
//   dup       : request arrived while a previous one is still held (dropped)
module arb_req_slot
    import rv32i_types::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     req,
    input  mem_req_t req_data,
    input  logic     clr,
    output mem_req_t slot,
    output logic     dup
);

    // A request in the completion cycle refills the slot instead of being
    // treated as a duplicate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= '0;
        end else if (req && (!slot.valid || clr)) begin
            slot <= req_data;
        end else if (clr) begin
            slot.valid <= 1'b0;
        end
    end

    assign dup = req && slot.valid && !clr;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory port between the fetch (imem) and data (dmem)
// ports. Requests are single-cycle mask pulses captured into one slot per
// port; dmem wins contention unless imem has lost STARVE_MAX times in a row.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mem_port_arbiter_if.slave (imem_*, dmem_*, mem_*, dmem_err)
module mem_port_arbiter
    import rv32i_types::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_t  state, state_n;
    logic [3:0]  starve_cnt, starve_cnt_n;
    logic        dmem_err_q;

    mem_req_t    i_in, d_in, i_slot, d_slot;
    logic        i_req, d_req, clr_i, clr_d, d_dup, i_dup_unused;

    logic [31:0] mem_addr, mem_wdata, imem_rdata, dmem_rdata;
    logic [3:0]  mem_rmask, mem_wmask;
    logic        imem_resp, dmem_resp;
    logic        grant_i, grant_d;

    assign i_req = |bus.imem_rmask;
    assign d_req = (|bus.dmem_rmask) || (|bus.dmem_wmask);

    assign i_in = '{valid: 1'b1, addr: bus.imem_addr, rmask: bus.imem_rmask,
                    wmask: 4'h0, wdata: 32'h0};
    // Store takes precedence when both masks are set.
    assign d_in = '{valid: 1'b1, addr: bus.dmem_addr,
                    rmask: (|bus.dmem_wmask) ? 4'h0 : bus.dmem_rmask,
                    wmask: bus.dmem_wmask, wdata: bus.dmem_wdata};

    arb_req_slot u_i_slot (
        .clk(clk), .rst(rst), .req(i_req), .req_data(i_in),
        .clr(clr_i), .slot(i_slot), .dup(i_dup_unused)
    );

    arb_req_slot u_d_slot (
        .clk(clk), .rst(rst), .req(d_req), .req_data(d_in),
        .clr(clr_d), .slot(d_slot), .dup(d_dup)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            dmem_err_q <= 1'b0;
        end else begin
            state      <= state_n;
            starve_cnt <= starve_cnt_n;
            dmem_err_q <= dmem_err_q | d_dup;
        end
    end

    always_comb begin
        state_n      = state;
        starve_cnt_n = starve_cnt;
        grant_i      = 1'b0;
        grant_d      = 1'b0;
        clr_i        = 1'b0;
        clr_d        = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_rmask    = '0;
        mem_wmask    = '0;
        imem_resp    = 1'b0;
        dmem_resp    = 1'b0;
        imem_rdata   = '0;
        dmem_rdata   = '0;

        unique case (state)
            IDLE: begin
                grant_i = i_slot.valid && (!d_slot.valid || starve_cnt == STARVE_LIM);
                grant_d = d_slot.valid && !grant_i;
                if (grant_i) begin
                    mem_addr     = i_slot.addr;
                    mem_wdata    = i_slot.wdata;
                    mem_rmask    = i_slot.rmask;
                    mem_wmask    = i_slot.wmask;
                    starve_cnt_n = '0;
                    state_n      = WAIT_I;
                end else if (grant_d) begin
                    mem_addr  = d_slot.addr;
                    mem_wdata = d_slot.wdata;
                    mem_rmask = d_slot.rmask;
                    mem_wmask = d_slot.wmask;
                    if (i_slot.valid && starve_cnt != STARVE_LIM) begin
                        starve_cnt_n = starve_cnt + 4'd1;
                    end
                    state_n = WAIT_D;
                end
            end
            WAIT_I: begin
                mem_addr  = i_slot.addr;
                mem_wdata = i_slot.wdata;
                if (bus.mem_resp) begin
                    imem_resp  = 1'b1;
                    imem_rdata = bus.mem_rdata;
                    clr_i      = 1'b1;
                    state_n    = IDLE;
                end
            end
            WAIT_D: begin
                mem_addr  = d_slot.addr;
                mem_wdata = d_slot.wdata;
                if (bus.mem_resp) begin
                    dmem_resp  = 1'b1;
                    dmem_rdata = bus.mem_rdata;
                    clr_d      = 1'b1;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.mem_rmask  = mem_rmask;
    assign bus.mem_wmask  = mem_wmask;
    assign bus.imem_resp  = imem_resp;
    assign bus.imem_rdata = imem_rdata;
    assign bus.dmem_resp  = dmem_resp;
    assign bus.dmem_rdata = dmem_rdata;
    assign bus.dmem_err   = dmem_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model of the
// arbitration rules.
module tb_mem_port_arbiter;

    localparam int unsigned SM = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.STARVE_MAX(SM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pending requests per port, which port owns the
    // memory (0 none, 1 imem, 2 dmem), consecutive imem losses, error flag.
    bit          m_ip, m_dp, m_err;
    int          m_busy, m_cnt;
    logic [31:0] m_ia, m_da, m_dwd;
    logic [3:0]  m_irm, m_drm, m_dwm;

    // Backing-memory behaviour
    int          lat = 1, wcnt = 0;
    bit          rand_lat = 0, force_resp = 0, fixed_en = 0;
    logic [31:0] fixed_rd = 32'h0;
    int          d_rereq = 0;

    // Observations from the last checked cycle
    logic [3:0]  o_rm, o_wm;
    logic [31:0] o_addr, o_wdata, o_irdata;
    logic        o_iresp, o_dresp, o_err;
    int          resp_log[$];
    int          wm_cycles;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.imem_rmask = 4'h0;
        bus.dmem_rmask = 4'h0;
        bus.dmem_wmask = 4'h0;
        bus.mem_resp   = 1'b0;
    endtask

    task automatic model_reset();
        m_ip = 0; m_dp = 0; m_err = 0; m_busy = 0; m_cnt = 0; wcnt = 0;
    endtask

    task automatic tick();
        int          win, port;
        logic        resp, clr_i, clr_d, i_req, d_req;
        logic [31:0] rd;
        logic [3:0]  e_rm, e_wm;
        resp = 1'b0;
        rd = fixed_en ? fixed_rd : $urandom;
        if (force_resp) begin
            resp = 1'b1;
            force_resp = 0;
        end else if (m_busy != 0) begin
            if (wcnt >= lat) begin
                resp = 1'b1;
                wcnt = 0;
                if (rand_lat) lat = int'($urandom_range(0, 3));
            end else begin
                wcnt++;
            end
        end
        if (resp && m_busy == 2 && d_rereq > 0) begin
            bus.dmem_rmask = 4'hF;
            bus.dmem_wmask = 4'h0;
            bus.dmem_addr  = 32'h0000_2100 + 32'(d_rereq * 4);
            d_rereq--;
        end
        bus.mem_resp  = resp;
        bus.mem_rdata = rd;

        win = 0;
        if (m_busy == 0) begin
            if (m_dp && m_ip) win = (m_cnt == int'(SM)) ? 1 : 2;
            else if (m_dp)    win = 2;
            else if (m_ip)    win = 1;
        end
        e_rm = 4'h0;
        e_wm = 4'h0;
        if (win == 1) e_rm = m_irm;
        else if (win == 2) begin e_rm = m_drm; e_wm = m_dwm; end

        @(negedge clk);
        o_rm = bus.mem_rmask;  o_wm = bus.mem_wmask;
        o_addr = bus.mem_addr; o_wdata = bus.mem_wdata;
        o_iresp = bus.imem_resp; o_irdata = bus.imem_rdata;
        o_dresp = bus.dmem_resp; o_err = bus.dmem_err;
        chk("mem_rmask", 32'(bus.mem_rmask), 32'(e_rm));
        chk("mem_wmask", 32'(bus.mem_wmask), 32'(e_wm));
        chk("imem_resp", 32'(bus.imem_resp), 32'(resp && m_busy == 1));
        chk("imem_rdata", bus.imem_rdata, (resp && m_busy == 1) ? rd : 32'h0);
        chk("dmem_resp", 32'(bus.dmem_resp), 32'(resp && m_busy == 2));
        chk("dmem_rdata", bus.dmem_rdata, (resp && m_busy == 2) ? rd : 32'h0);
        port = (win != 0) ? win : m_busy;
        if (port == 1) chk("mem_addr_i", bus.mem_addr, m_ia);
        if (port == 2) begin
            chk("mem_addr_d", bus.mem_addr, m_da);
            chk("mem_wdata", bus.mem_wdata, m_dwd);
        end
        chk("dmem_err", 32'(bus.dmem_err), 32'(m_err));
        if (bus.imem_resp) resp_log.push_back(1);
        if (bus.dmem_resp) resp_log.push_back(2);
        if (bus.mem_wmask != 4'h0) wm_cycles++;

        @(posedge clk);
        i_req = |bus.imem_rmask;
        d_req = (|bus.dmem_rmask) || (|bus.dmem_wmask);
        clr_i = resp && m_busy == 1;
        clr_d = resp && m_busy == 2;
        if (win == 1) begin
            m_busy = 1; m_cnt = 0; wcnt = 0;
        end else if (win == 2) begin
            m_busy = 2; wcnt = 0;
            if (m_ip && m_cnt < int'(SM)) m_cnt++;
        end
        if (clr_i || clr_d) m_busy = 0;
        if (clr_i) m_ip = 0;
        if (clr_d) m_dp = 0;
        if (i_req && !m_ip) begin
            m_ip = 1; m_ia = bus.imem_addr; m_irm = bus.imem_rmask;
        end
        if (d_req) begin
            if (!m_dp) begin
                m_dp = 1; m_da = bus.dmem_addr; m_dwd = bus.dmem_wdata;
                m_dwm = bus.dmem_wmask;
                m_drm = (bus.dmem_wmask != 4'h0) ? 4'h0 : bus.dmem_rmask;
            end else begin
                m_err = 1;
            end
        end
        #1;
        clear_inputs();
    endtask

    task automatic drain();
        int  guard;
        bit  done;
        guard = 0;
        while ((m_busy != 0 || m_ip || m_dp) && guard < 60) begin
            tick();
            guard++;
        end
        done = (m_busy == 0 && !m_ip && !m_dp);
        n_cmp++;
        assert (done) else begin
            n_bad++;
            $error("FAIL drain: observed still_busy=1 expected still_busy=0");
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.mem_resp = 1'b0;
        #1;
        model_reset();
        chk("rst_imem_resp", 32'(bus.imem_resp), 32'h0);
        chk("rst_dmem_resp", 32'(bus.dmem_resp), 32'h0);
        chk("rst_imem_rdata", bus.imem_rdata, 32'h0);
        chk("rst_dmem_rdata", bus.dmem_rdata, 32'h0);
        chk("rst_mem_rmask", 32'(bus.mem_rmask), 32'h0);
        chk("rst_mem_wmask", 32'(bus.mem_wmask), 32'h0);
        chk("rst_dmem_err", 32'(bus.dmem_err), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic req_i(input logic [31:0] a);
        bus.imem_addr = a;
        bus.imem_rmask = 4'hF;
    endtask

    task automatic req_d(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                         input logic [31:0] wd);
        bus.dmem_addr = a; bus.dmem_rmask = rm; bus.dmem_wmask = wm; bus.dmem_wdata = wd;
    endtask

    initial begin
        bus.imem_addr = '0; bus.dmem_addr = '0; bus.dmem_wdata = '0; bus.mem_rdata = '0;
        clear_inputs();
        model_reset();
        do_reset();

        // imem-only path with fixed latency and data
        lat = 1; fixed_en = 1; fixed_rd = 32'hDEAD_BEEF;
        req_i(32'h0000_1000);
        tick();                                   // cycle 0
        tick();                                   // cycle 1: issue
        chk("i_issue_rmask", 32'(o_rm), 32'hF);
        chk("i_issue_addr", o_addr, 32'h0000_1000);
        tick();                                   // cycle 2: waiting
        chk("i_wait_rmask", 32'(o_rm), 32'h0);
        tick();                                   // cycle 3: response
        chk("i_resp", 32'(o_iresp), 32'h1);
        chk("i_rdata", o_irdata, 32'hDEAD_BEEF);
        chk("i_resp_rmask", 32'(o_rm), 32'h0);
        fixed_en = 0;

        // Simultaneous requests: dmem first, then imem
        resp_log.delete();
        req_i(32'h0000_1000);
        req_d(32'h0000_2004, 4'b0011, 4'b0000, 32'h0);
        tick();
        drain();
        chk("sim_count", 32'(resp_log.size()), 32'd2);
        chk("sim_first", 32'(resp_log[0]), 32'd2);
        chk("sim_second", 32'(resp_log[1]), 32'd1);

        // Starvation guard: D, D, I, then the last refill D
        lat = 0;
        resp_log.delete();
        req_i(32'h0000_1100);
        req_d(32'h0000_2000, 4'hF, 4'h0, 32'h0);
        d_rereq = 2;
        tick();
        drain();
        chk("starve_count", 32'(resp_log.size()), 32'd4);
        chk("starve_g0", 32'(resp_log[0]), 32'd2);
        chk("starve_g1", 32'(resp_log[1]), 32'd2);
        chk("starve_g2", 32'(resp_log[2]), 32'd1);
        chk("starve_g3", 32'(resp_log[3]), 32'd2);
        // Counter cleared by the imem grant: dmem wins again
        resp_log.delete();
        req_i(32'h0000_1200);
        req_d(32'h0000_2200, 4'hF, 4'h0, 32'h0);
        tick();
        drain();
        chk("clr_first", 32'(resp_log[0]), 32'd2);

        // Store path
        lat = 2;
        wm_cycles = 0;
        req_d(32'h0000_3000, 4'h0, 4'b1100, 32'hABCD_0000);
        tick();
        tick();
        chk("st_wmask", 32'(o_wm), 32'hC);
        chk("st_wdata", o_wdata, 32'hABCD_0000);
        drain();
        chk("st_wm_cycles", 32'(wm_cycles), 32'd1);
        // Both masks set: treated as a store
        req_d(32'h0000_3004, 4'hF, 4'b0011, 32'h0000_1234);
        tick();
        tick();
        chk("st_both_rmask", 32'(o_rm), 32'h0);
        chk("st_both_wmask", 32'(o_wm), 32'h3);
        drain();

        // Duplicate dmem request, then a legal refill in the response cycle
        resp_log.delete();
        req_d(32'h0000_4000, 4'hF, 4'h0, 32'h0);
        tick();
        req_d(32'h0000_4444, 4'h1, 4'h0, 32'h0);
        d_rereq = 1;
        tick();
        chk("dup_addr_kept", o_addr, 32'h0000_4000);
        drain();
        chk("dup_err", 32'(o_err), 32'h1);
        chk("dup_refill", 32'(resp_log.size()), 32'd2);

        // Reset mid-operation in WAIT_D with imem pending; late resp ignored
        do_reset();
        lat = 3;
        req_i(32'h0000_5000);
        req_d(32'h0000_6000, 4'hF, 4'h0, 32'h0);
        tick();
        tick();
        tick();
        do_reset();
        force_resp = 1;
        tick();
        chk("late_dresp", 32'(o_dresp), 32'h0);
        chk("late_iresp", 32'(o_iresp), 32'h0);
        chk("late_issue", 32'(o_rm), 32'h0);
        tick();

        // Randomized traffic
        rand_lat = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req_i({$urandom_range(0, 32'hFFFF), 2'b00});
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0: req_d({$urandom_range(0, 32'hFFFF), 2'b00}, 4'($urandom_range(1, 15)), 4'h0, $urandom);
                    1: req_d({$urandom_range(0, 32'hFFFF), 2'b00}, 4'h0, 4'($urandom_range(1, 15)), $urandom);
                    default: req_d({$urandom_range(0, 32'hFFFF), 2'b00}, 4'($urandom_range(1, 15)),
                                   4'($urandom_range(1, 15)), $urandom);
                endcase
            end
            if (m_busy == 0 && $urandom_range(0, 7) == 0) force_resp = 1;
            if (i == 200) do_reset();
            tick();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
